// File: rtl/bure_pipe_pkg.sv
// Shared BureCore pipeline types and helpers.
// Payload structs carried by the inter-stage elastic buffers.
package bure_pipe_pkg;

    localparam int BURE_STAGE_DEPTH_DEFAULT = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } bure_if_payload_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_wen;
        logic [31:0] imm;
        logic        is_alu_op;
        logic        is_load_op;
        logic        is_store_op;
        logic        is_branch_op;
        logic        is_jump_op;
    } bure_id_payload_t;

endpackage

// File: rtl/bure_stage_fifo_mem.sv
// Storage array for bure_stage_fifo: DEPTH x DATA_WIDTH, no reset.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (comb read).
module bure_stage_fifo_mem
    import bure_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = BURE_STAGE_DEPTH_DEFAULT,
    parameter int PTR_W      = 1
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bure_stage_fifo.sv
// Elastic valid/ready buffer between BureCore pipeline stages, with flush.
// Ports: clk, rst (async high), flush, up_* (in side), dn_* (out side), count.
// Option: BURE_STAGE_FIFO_BYPASS_EN adds a comb up->dn path when empty.
module bure_stage_fifo
    import bure_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = BURE_STAGE_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         up_valid,
    output logic                         up_ready,
    input  logic [DATA_WIDTH-1:0]        up_data,
    output logic                         dn_valid,
    input  logic                         dn_ready,
    output logic [DATA_WIDTH-1:0]        dn_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bure_stage_fifo: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("bure_stage_fifo: DATA_WIDTH must be >= 1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full, empty;
    logic                  buf_valid;
    logic                  push, pop, wr_en;
    logic                  byp_ok, byp_take;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on occupancy, never on dn_ready.
    assign up_ready  = !rst && !flush && !full;
    assign buf_valid = !flush && !empty;

`ifdef BURE_STAGE_FIFO_BYPASS_EN
    assign byp_ok   = !rst && !flush && empty;
    assign byp_take = byp_ok && up_valid && dn_ready;
`else
    assign byp_ok   = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign push  = up_valid && up_ready;
    assign pop   = buf_valid && dn_ready;
    // A bypassed entry leaves in the same cycle and is never stored.
    assign wr_en = push && !byp_take;

    assign dn_valid = buf_valid || (byp_ok && up_valid);
    assign count    = count_q;

    always_comb begin
        dn_data = '0;
        if (buf_valid) begin
            dn_data = rd_data;
        end else if (byp_ok && up_valid) begin
            dn_data = up_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    bure_stage_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (up_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    a_count_bound: assert property (
        @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: tb/tb_bure_stage_fifo.sv
// Scoreboard bench for bure_stage_fifo at DEPTH 2, 4 and 8.
// Stimulus posts expectations; a negedge monitor pops and compares.
module tb_bure_stage_fifo;

`ifdef BURE_STAGE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  uv, ur, dv, dr, fl;
    logic [31:0] ud [3];
    logic [31:0] dd0, dd1, dd2;
    logic [1:0]  c0;
    logic [2:0]  c1;
    logic [3:0]  c2;

    bure_stage_fifo #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(fl[0]),
        .up_valid(uv[0]), .up_ready(ur[0]), .up_data(ud[0]),
        .dn_valid(dv[0]), .dn_ready(dr[0]), .dn_data(dd0),
        .count(c0)
    );

    bure_stage_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .flush(fl[1]),
        .up_valid(uv[1]), .up_ready(ur[1]), .up_data(ud[1]),
        .dn_valid(dv[1]), .dn_ready(dr[1]), .dn_data(dd1),
        .count(c1)
    );

    bure_stage_fifo #(.DATA_WIDTH(32), .DEPTH(8)) u_d8 (
        .clk(clk), .rst(rst), .flush(fl[2]),
        .up_valid(uv[2]), .up_ready(ur[2]), .up_data(ud[2]),
        .dn_valid(dv[2]), .dn_ready(dr[2]), .dn_data(dd2),
        .count(c2)
    );

    typedef struct {
        int          k;
        int          sig;
        logic [31:0] e;
        string       name;
    } chk_t;

    chk_t        chk_q [$];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] exp2 [$];

    int n_run  = 0;
    int n_fail = 0;

    function automatic int qs(int k);
        case (k)
            0:       return exp0.size();
            1:       return exp1.size();
            default: return exp2.size();
        endcase
    endfunction

    function automatic logic [31:0] dd_of(int k);
        case (k)
            0:       return dd0;
            1:       return dd1;
            default: return dd2;
        endcase
    endfunction

    function automatic logic [31:0] cnt_of(int k);
        case (k)
            0:       return {30'b0, c0};
            1:       return {29'b0, c1};
            default: return {28'b0, c2};
        endcase
    endfunction

    // sig: 0 up_ready, 1 dn_valid, 2 dn_data, 3 count, 4 scoreboard depth
    function automatic logic [31:0] act(int k, int sig);
        case (sig)
            0:       return {31'b0, ur[k]};
            1:       return {31'b0, dv[k]};
            2:       return dd_of(k);
            3:       return cnt_of(k);
            default: return qs(k);
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] a;
        chk_t        c;
        for (int k = 0; k < 3; k++) begin
            if (dv[k] && dr[k]) begin
                n_run++;
                if (qs(k) == 0) begin
                    n_fail++;
                    $display("FAIL pop[%0d]: got %0h, expected no entry",
                             k, dd_of(k));
                end else begin
                    case (k)
                        0:       e = exp0.pop_front();
                        1:       e = exp1.pop_front();
                        default: e = exp2.pop_front();
                    endcase
                    if (dd_of(k) !== e) begin
                        n_fail++;
                        $display("FAIL pop[%0d]: got %0h, expected %0h",
                                 k, dd_of(k), e);
                    end
                end
            end
        end
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_run++;
            a = act(c.k, c.sig);
            if (a !== c.e) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %0h, expected %0h",
                         c.name, c.k, a, c.e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int k, input int sig,
                        input logic [31:0] e, input string nm);
        chk_t c;
        c.k    = k;
        c.sig  = sig;
        c.e    = e;
        c.name = nm;
        chk_q.push_back(c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mcnt;
        int  seq;
        bit  pend;
        bit  push_m;
        bit  pop_m;

        rst = 1'b1;
        uv  = '0;
        dr  = '0;
        fl  = '0;
        for (int k = 0; k < 3; k++) ud[k] = '0;

        // reset state and release
        cyc();
        for (int k = 0; k < 3; k++) post(k, 0, 0, "rst_up_ready");
        post(1, 1, 0, "rst_dn_valid");
        post(1, 3, 0, "rst_count");
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) post(k, 0, 1, "rel_up_ready");

        // fill / drain, DEPTH=4
        for (int i = 0; i < 4; i++) begin
            cyc();
            uv[1] = 1'b1;
            ud[1] = 32'h11 * (i + 1);
            exp1.push_back(ud[1]);
            post(1, 3, i, "fill_count");
            post(1, 0, 1, "fill_up_ready");
        end
        cyc();
        uv[1] = 1'b0;
        post(1, 0, 0, "full_up_ready");
        post(1, 3, 4, "full_count");
        post(1, 1, 1, "full_dn_valid");
        post(1, 2, 32'h11, "full_head");
        for (int i = 0; i < 4; i++) begin
            cyc();
            dr[1] = 1'b1;
            post(1, 3, 4 - i, "drain_count");
        end
        cyc();
        post(1, 3, 0, "drained_count");
        post(1, 1, 0, "empty_dn_valid");
        post(1, 2, 0, "empty_dn_data");

        // reset mid-stream with two entries held
        cyc();
        dr[1] = 1'b0;
        uv[1] = 1'b1;
        ud[1] = 32'hC1;
        exp1.push_back(ud[1]);
        cyc();
        ud[1] = 32'hC2;
        exp1.push_back(ud[1]);
        cyc();
        uv[1] = 1'b0;
        post(1, 3, 2, "held_count");
        post(1, 1, 1, "held_dn_valid");
        cyc();
        rst = 1'b1;
        exp1.delete();
        post(1, 1, 0, "midrst_dn_valid");
        post(1, 3, 0, "midrst_count");
        post(1, 2, 0, "midrst_dn_data");
        post(1, 0, 0, "midrst_up_ready");
        cyc();
        rst = 1'b0;
        post(1, 0, 1, "midrel_up_ready");
        post(1, 3, 0, "midrel_count");

        // flush with three entries held
        for (int i = 0; i < 3; i++) begin
            cyc();
            uv[1] = 1'b1;
            ud[1] = 32'hA1 + i;
            exp1.push_back(ud[1]);
        end
        cyc();
        ud[1] = 32'hEE;
        dr[1] = 1'b1;
        fl[1] = 1'b1;
        exp1.delete();
        post(1, 0, 0, "flush_up_ready");
        post(1, 1, 0, "flush_dn_valid");
        post(1, 2, 0, "flush_dn_data");
        cyc();
        fl[1] = 1'b0;
        uv[1] = 1'b0;
        post(1, 3, 0, "postflush_count");
        post(1, 1, 0, "postflush_dn_valid");
        cyc();
        dr[1] = 1'b0;
        uv[1] = 1'b1;
        ud[1] = 32'h55;
        exp1.push_back(ud[1]);
        post(1, 3, 0, "refill_count");
        cyc();
        uv[1] = 1'b0;
        dr[1] = 1'b1;
        post(1, 2, 32'h55, "refill_head");
        post(1, 3, 1, "refill_count1");
        cyc();
        dr[1] = 1'b0;
        post(1, 3, 0, "refill_count0");

        // concurrent push/pop with wrap, DEPTH=2
        cyc();
        uv[0] = 1'b1;
        ud[0] = 32'd1;
        dr[0] = 1'b0;
        exp0.push_back(ud[0]);
        post(0, 3, 0, "wrap_start_count");
        for (int d = 2; d <= 10; d++) begin
            cyc();
            ud[0] = d;
            dr[0] = 1'b1;
            exp0.push_back(ud[0]);
            post(0, 3, 1, "wrap_count");
            post(0, 0, 1, "wrap_up_ready");
        end
        cyc();
        uv[0] = 1'b0;
        post(0, 3, 1, "wrap_tail_count");
        cyc();
        dr[0] = 1'b0;
        post(0, 3, 0, "wrap_end_count");

        // bypass / one-cycle latency from empty
        cyc();
        uv[0] = 1'b1;
        ud[0] = 32'hAB;
        dr[0] = 1'b1;
        exp0.push_back(ud[0]);
        post(0, 3, 0, "byp_count");
        post(0, 1, {31'b0, BYP}, "byp_dn_valid");
        post(0, 2, BYP ? 32'hAB : 32'h0, "byp_dn_data");
        cyc();
        uv[0] = 1'b0;
        post(0, 1, {31'b0, !BYP}, "lat_dn_valid");
        post(0, 2, BYP ? 32'h0 : 32'hAB, "lat_dn_data");
        post(0, 3, {31'b0, !BYP}, "lat_count");
        cyc();
        dr[0] = 1'b0;
        post(0, 3, 0, "lat_end_count");
        post(0, 1, 0, "lat_end_dn_valid");

        // random backpressure, DEPTH=8, count model
        mcnt = 0;
        seq  = 32'h1000;
        pend = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            cyc();
            if (!pend) begin
                uv[2] = ($urandom_range(0, 3) != 0);
                if (uv[2]) begin
                    seq++;
                    ud[2] = seq;
                end
            end
            if (n < 5000) dr[2] = ($urandom_range(0, 2) == 0);
            else          dr[2] = ($urandom_range(0, 2) != 0);
            push_m = uv[2] && (mcnt < 8);
            pop_m  = dr[2] && ((mcnt != 0) || (BYP && uv[2]));
            post(2, 3, mcnt, "rand_count");
            post(2, 0, {31'b0, mcnt < 8}, "rand_up_ready");
            if (push_m) exp2.push_back(ud[2]);
            mcnt = mcnt + int'(push_m) - int'(pop_m);
            pend = uv[2] && !push_m;
        end
        cyc();
        uv[2] = 1'b0;
        dr[2] = 1'b1;
        repeat (10) cyc();
        dr[2] = 1'b0;
        post(2, 3, 0, "rand_end_count");
        for (int k = 0; k < 3; k++) post(k, 4, 0, "sb_leftover");

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
